// File: rtl/pulse_merger_pkg.sv
// Shared types for the pulse merger: FSM state encoding and gap-timer sizing.
package pulse_merger_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   // Smallest width able to hold the value gap (at least one bit).
   function automatic int gap_width(input int gap);
      return (gap < 2) ? 1 : $clog2(gap + 1);
   endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// One-cycle strobe on each 0->1 transition of sig_in; used by pulse_merger in edge mode.
module rising_edge_detector (
   input  logic clock,
   input  logic resetn,
   input  logic sig_in,
   output logic rise_out
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = sig_in;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/pulse_merger.sv
// Merges a burst of separated input pulses into one contiguous output pulse of equal length.
// Define PULSE_MERGER_EDGE_MODE_EN to count only rising edges of pulse_in as pulses.
module pulse_merger
   import pulse_merger_pkg::*;
#(
   parameter int PULSE_COUNTER_WIDTH = 4,
   parameter int GAP_CYCLES          = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic pulse_in,
   output logic pulse_out,
   output logic busy
);

   localparam int                             GAP_W   = gap_width(GAP_CYCLES);
   localparam logic [GAP_W-1:0]               GAP_MAX = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0]               GAP_ONE = GAP_W'(1);
   localparam logic [PULSE_COUNTER_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [PULSE_COUNTER_WIDTH-1:0] CNT_ONE = PULSE_COUNTER_WIDTH'(1);

   state_t                         state_q, state_d;
   logic [PULSE_COUNTER_WIDTH-1:0] count_q, count_d;
   logic [GAP_W-1:0]               gap_q, gap_d;
   logic                           pulse_evt;
   logic                           accept;

`ifdef PULSE_MERGER_EDGE_MODE_EN
   rising_edge_detector u_edge (
      .clock    (clock),
      .resetn   (resetn),
      .sig_in   (pulse_in),
      .rise_out (pulse_evt)
   );
`else
   assign pulse_evt = pulse_in;
`endif

   assign busy      = (count_q == CNT_MAX);
   assign accept    = pulse_evt & ~busy;
   assign pulse_out = (state_q == EMIT);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               count_d = CNT_ONE;
               gap_d   = '0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (accept) begin
               count_d = count_q + CNT_ONE;
            end
            // The gap is measured on the raw input, independent of edge mode.
            if (pulse_in) begin
               gap_d = '0;
            end else if (gap_q != GAP_MAX) begin
               gap_d = gap_q + GAP_ONE;
            end
            if (busy || (gap_d == GAP_MAX)) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            gap_d = '0;
            if (!accept && (count_q != '0)) begin
               count_d = count_q - CNT_ONE;
            end
            if (count_d == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         count_q <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         gap_q   <= gap_d;
      end
   end

endmodule
